// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler that shares one small signed ALU between two requesters.
// Optional per-requester completion counters are built when ALU_SHARE_STATS_EN is defined.
module alu_share_ctrl #(
    parameter int NBITS       = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [NBITS-1:0] a0,
    input  logic [NBITS-1:0] b0,
    input  logic [1:0]       op0,
    input  logic [NBITS-1:0] a1,
    input  logic [NBITS-1:0] b1,
    input  logic [1:0]       op1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             ovf,
    output logic [7:0]       seg,
    output logic [7:0]       count0,
    output logic [7:0]       count1
);

    // state  | meaning
    // S_IDLE | waiting for a request, arbitration happens at the edge
    // S_EXEC | ALU running on latched operands, exec counter counting down
    // S_DONE | done pulse to the winner, requests not sampled
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_win;
    logic             r_gnt;
    logic [3:0]       r_cnt;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic [1:0]       r_op;
    logic [NBITS-1:0] r_result;
    logic             r_ovf;

    logic             w_start;
    logic             w_win;
    logic             w_finish;
    logic [NBITS-1:0] w_alu;
    logic             w_alu_ovf;
    logic [1:0]       w_win_oh;

    // Tie goes to the requester that did not win last time.
    assign w_win    = (req == 2'b11) ? ~r_last : req[1];
    assign w_start  = (r_state == S_IDLE) && (req != 2'b00);
    assign w_finish = (r_state == S_EXEC) && (r_cnt == 4'd0);
    assign w_win_oh = r_win ? 2'b10 : 2'b01;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req != 2'b00) w_next = S_EXEC;
            S_EXEC:  if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu     = '0;
        w_alu_ovf = 1'b0;
        case (r_op)
            2'b00: begin
                w_alu     = r_a + r_b;
                w_alu_ovf = (r_a[NBITS-1] == r_b[NBITS-1]) && (w_alu[NBITS-1] != r_a[NBITS-1]);
            end
            2'b01: begin
                w_alu     = r_a - r_b;
                w_alu_ovf = (r_a[NBITS-1] != r_b[NBITS-1]) && (w_alu[NBITS-1] != r_a[NBITS-1]);
            end
            2'b10:   w_alu = r_a & r_b;
            default: w_alu = r_a | r_b;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_win    <= 1'b0;
            r_gnt    <= 1'b0;
            r_cnt    <= 4'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 2'b00;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_gnt <= w_start;
            if (w_start) begin
                r_win  <= w_win;
                r_last <= w_win;
                r_cnt  <= EXEC_LOAD;
                r_a    <= w_win ? a1 : a0;
                r_b    <= w_win ? b1 : b0;
                r_op   <= w_win ? op1 : op0;
            end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_finish) begin
                r_result <= w_alu;
                r_ovf    <= w_alu_ovf;
            end
        end
    end

    assign gnt    = r_gnt ? w_win_oh : 2'b00;
    assign done   = (r_state == S_DONE) ? w_win_oh : 2'b00;
    assign busy   = (r_state != S_IDLE);
    assign result = r_result;
    assign ovf    = r_ovf;

    // Bit 7 is the minus dot; negative values show their magnitude.
    generate
        if (NBITS == 3) begin : g_seg
            always_comb begin
                seg = 8'h00;
                case (r_result)
                    3'b000:  seg = 8'h3F;
                    3'b001:  seg = 8'h06;
                    3'b010:  seg = 8'h5B;
                    3'b011:  seg = 8'h4F;
                    3'b100:  seg = 8'hE6;
                    3'b101:  seg = 8'hCF;
                    3'b110:  seg = 8'hDB;
                    default: seg = 8'h86;
                endcase
            end
        end else begin : g_no_seg
            assign seg = 8'h00;
        end
    endgenerate

`ifdef ALU_SHARE_STATS_EN
    logic [7:0] r_count0;
    logic [7:0] r_count1;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_count0 <= 8'h00;
            r_count1 <= 8'h00;
        end else if (w_finish) begin
            if (r_win) r_count1 <= r_count1 + 8'h01;
            else       r_count0 <= r_count0 + 8'h01;
        end
    end

    assign count0 = r_count0;
    assign count1 = r_count1;
`else
    assign count0 = 8'h00;
    assign count1 = 8'h00;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized bench for alu_share_ctrl: two instances (EXEC_CYCLES 1 and 4) against
// a transaction-level schedule model; counters follow ALU_SHARE_STATS_EN.
module tb_alu_share_ctrl;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [NB-1:0] a0, b0, a1, b1;
    logic [1:0]    op0, op1;

    logic [1:0]    gnt_1, done_1, gnt_4, done_4;
    logic          busy_1, busy_4, ovf_1, ovf_4;
    logic [NB-1:0] res_1, res_4;
    logic [7:0]    seg_1, seg_4, c0_1, c1_1, c0_4, c1_4;

    always #5 clk = ~clk;

    alu_share_ctrl #(.NBITS(NB), .EXEC_CYCLES(1)) u_dut1 (
        .clk_2(clk), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
        .gnt(gnt_1), .done(done_1), .busy(busy_1), .result(res_1), .ovf(ovf_1),
        .seg(seg_1), .count0(c0_1), .count1(c1_1));

    alu_share_ctrl #(.NBITS(NB), .EXEC_CYCLES(4)) u_dut4 (
        .clk_2(clk), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
        .gnt(gnt_4), .done(done_4), .busy(busy_4), .result(res_4), .ovf(ovf_4),
        .seg(seg_4), .count0(c0_4), .count1(c1_4));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Schedule model: each op is a (grant cycle, done cycle) pair plus the next free sample edge.
    int m_e[2] = '{1, 4};
    int m_free[2], m_gnt_at[2], m_done_at[2], m_w[2], m_last[2];
    int m_pres[2], m_povf[2], m_res[2], m_ovf[2], m_cnt0[2], m_cnt1[2];
    int ops_done1;
    logic [7:0] seg_tab [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'hE6, 8'hCF, 8'hDB, 8'h86};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void alu_ref(input int a, input int b, input int op, output int r, output int o);
        int sa, sb, t;
        int half = 1 << (NB - 1);
        int full = 1 << NB;
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        o  = 0;
        case (op)
            0: t = sa + sb;
            1: t = sa - sb;
            2: t = a & b;
            default: t = a | b;
        endcase
        if (op < 2) o = (t < -half || t > half - 1) ? 1 : 0;
        r = t & (full - 1);
    endfunction

    function automatic void model_edge(input int k, input int n);
        int w, r, o;
        if (reset) begin
            m_free[k] = n + 1; m_gnt_at[k] = -100; m_done_at[k] = -100;
            m_res[k] = 0; m_ovf[k] = 0; m_last[k] = 1; m_cnt0[k] = 0; m_cnt1[k] = 0;
            return;
        end
        if (n == m_done_at[k]) begin
            m_res[k] = m_pres[k];
            m_ovf[k] = m_povf[k];
            if (m_w[k] == 0) m_cnt0[k] = (m_cnt0[k] + 1) % 256;
            else             m_cnt1[k] = (m_cnt1[k] + 1) % 256;
            if (k == 0) ops_done1++;
        end
        if (n >= m_free[k] && req != 2'b00) begin
            w = (req == 2'b11) ? 1 - m_last[k] : ((req == 2'b10) ? 1 : 0);
            if (w == 0) alu_ref(int'(a0), int'(b0), int'(op0), r, o);
            else        alu_ref(int'(a1), int'(b1), int'(op1), r, o);
            m_w[k] = w; m_last[k] = w; m_pres[k] = r; m_povf[k] = o;
            m_gnt_at[k] = n; m_done_at[k] = n + m_e[k]; m_free[k] = n + m_e[k] + 2;
        end
    endfunction

    task automatic compare_dut(input int k, input int n, input logic [1:0] g, input logic [1:0] d,
                               input logic b, input logic [NB-1:0] res, input logic o,
                               input logic [7:0] s, input logic [7:0] c0, input logic [7:0] c1);
        int eg, ed, eb, ec0, ec1;
        eg = (n == m_gnt_at[k])  ? (1 << m_w[k]) : 0;
        ed = (n == m_done_at[k]) ? (1 << m_w[k]) : 0;
        eb = (n >= m_gnt_at[k] && n <= m_done_at[k]) ? 1 : 0;
`ifdef ALU_SHARE_STATS_EN
        ec0 = m_cnt0[k]; ec1 = m_cnt1[k];
`else
        ec0 = 0; ec1 = 0;
`endif
        check($sformatf("gnt%0d", m_e[k]), 32'(g), 32'(eg));
        check($sformatf("done%0d", m_e[k]), 32'(d), 32'(ed));
        check($sformatf("busy%0d", m_e[k]), 32'(b), 32'(eb));
        check($sformatf("result%0d", m_e[k]), 32'(res), 32'(m_res[k]));
        check($sformatf("ovf%0d", m_e[k]), 32'(o), 32'(m_ovf[k]));
        check($sformatf("seg%0d", m_e[k]), 32'(s), 32'(seg_tab[m_res[k]]));
        check($sformatf("count0_%0d", m_e[k]), 32'(c0), 32'(ec0));
        check($sformatf("count1_%0d", m_e[k]), 32'(c1), 32'(ec1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, cyc);
        model_edge(1, cyc);
        @(negedge clk);
        compare_dut(0, cyc, gnt_1, done_1, busy_1, res_1, ovf_1, seg_1, c0_1, c1_1);
        compare_dut(1, cyc, gnt_4, done_4, busy_4, res_4, ovf_4, seg_4, c0_4, c1_4);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; req = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = 2'b00; op1 = 2'b00;
        steps(2);
        reset = 1'b0;
        steps(1);

        req = 2'b01; a0 = 3'b001; b0 = 3'b010; op0 = 2'b00;
        steps(1);
        req = 2'b00;
        steps(6);
        check("tp_add_res", 32'(res_1), 32'd3);
        check("tp_add_seg", 32'(seg_1), 32'h4F);

        req = 2'b10; a1 = 3'b011; b1 = 3'b001; op1 = 2'b00;
        steps(1);
        req = 2'b00;
        steps(6);
        check("tp_ovf_res", 32'(res_4), 32'd4);
        check("tp_ovf_flag", 32'(ovf_1), 32'd1);
        check("tp_ovf_seg", 32'(seg_1), 32'hE6);

        req = 2'b11; a0 = 3'b011; b0 = 3'b001; op0 = 2'b01; a1 = 3'b000; b1 = 3'b001; op1 = 2'b01;
        steps(3);
        check("tp_rr_res0", 32'(res_1), 32'd2);
        steps(3);
        check("tp_rr_res1", 32'(res_1), 32'd7);
        check("tp_rr_seg1", 32'(seg_1), 32'h86);
        steps(3);
        req = 2'b00;
        steps(6);

        req = 2'b01; op0 = 2'b10; a0 = 3'b110; b0 = 3'b011;
        steps(1);
        req = 2'b00;
        steps(6);
        check("tp_and_res4", 32'(res_4), 32'd2);

        req = 2'b01; op0 = 2'b00; a0 = 3'b001; b0 = 3'b001;
        steps(2);
        req = 2'b00; reset = 1'b1;
        steps(1);
        reset = 1'b0;
        check("tp_abort_res", 32'(res_4), 32'd0);
        check("tp_abort_seg", 32'(seg_4), 32'h3F);
        check("tp_abort_busy", 32'(busy_4), 32'd0);
        req = 2'b11;
        steps(1);
        check("tp_abort_gnt", 32'(gnt_4), 32'd1);
        req = 2'b00;
        steps(6);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            req   = 2'($urandom_range(0, 3));
            a0 = NB'($urandom); b0 = NB'($urandom); op0 = 2'($urandom);
            a1 = NB'($urandom); b1 = NB'($urandom); op1 = 2'($urandom);
            steps(1);
        end

        reset = 1'b1; req = 2'b00;
        steps(1);
        reset = 1'b0; ops_done1 = 0;
        req = 2'b01;
        for (int i = 0; i < 1000 && ops_done1 < 256; i++) begin
            a0 = NB'($urandom); b0 = NB'($urandom); op0 = 2'($urandom);
            steps(1);
        end
        check("wrap_ops", 32'(ops_done1), 32'd256);
        check("wrap_count0", 32'(c0_1), 32'd0);
        check("wrap_count1", 32'(c1_1), 32'd0);
        req = 2'b00;
        steps(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Scheduler for the small signed ALU used on the board (add/sub/and/or).
- Shares one ALU instance between two requesters using a round-robin req/gnt/done handshake.
- Latches the winner's operands, runs the ALU for a configurable number of cycles, and returns the result and an overflow flag.
- Drives the 7-segment pattern of the last result. Sits between switch/requester logic and the LED/SEG outputs of top.

Parameters:
- NBITS, 3: operand/result width, two's complement. SEG decode is defined only for NBITS=3; for any other width, seg is held at 8'h00.
- EXEC_CYCLES, 1: cycles spent in EXEC (1..15). Models a slow ALU.

Ports:
- clk_2  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  2  request per requester; bit i = requester i
- a0, b0  input  NBITS each  operands, requester 0
- op0  input  2  opcode, requester 0: 00 add, 01 sub, 10 and, 11 or
- a1, b1  input  NBITS each  operands, requester 1
- op1  input  2  opcode, requester 1
- gnt  output  2  one-hot grant pulse, 1 cycle
- done  output  2  one-hot completion pulse, 1 cycle
- busy  output  1  high in any state other than IDLE
- result  output  NBITS  last completed result
- ovf  output  1  signed overflow of last completed op
- seg  output  8  7-segment pattern of result
- count0, count1  output  8 each  completed-op counters (see Optional Feature)

Behaviour:
- Reset, when sampled high at a clock edge:
  - state=IDLE; gnt=0, done=0, busy=0.
  - result=0, ovf=0, seg=8'h3F.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Counters=0.
  - Reset mid-operation aborts the operation: no done pulse, no result update.
- States: IDLE, EXEC, DONE.
- IDLE:
  - At an edge with req!=0, pick a winner w. If exactly one bit is set, that requester wins; if both are set, w = ~last.
  - Capture a_w/b_w/op_w into internal registers, set last=w.
  - Next cycle: gnt[w]=1 for exactly one cycle; state=EXEC; exec counter loaded with EXEC_CYCLES-1.
  - With req=0: stay in IDLE.
- EXEC:
  - Counter decrements each cycle.
  - At the edge where the counter is 0: register result and ovf computed from the latched operands, update seg, go to DONE.
  - Requests are ignored; req changes after the grant do not affect the operation.
- DONE: done[w]=1 for one cycle; next state is IDLE. Requests are not sampled in DONE.
- Latency:
  - gnt is asserted in the cycle after req is sampled.
  - done is asserted EXEC_CYCLES cycles after the gnt cycle.
  - With EXEC_CYCLES=1, back-to-back ops take 3 cycles each.
- Arithmetic:
  - Result is NBITS wide; carries are discarded (mod 2^NBITS).
  - Add: ovf = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - Sub: ovf = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - And/or: ovf=0.
- Hold: result, ovf and seg hold their value until the next completion.
- seg (NBITS=3, bit7 = minus dot), by result:
  - 000→3F, 001→06, 010→5B, 011→4F
  - 111→86, 110→DB, 101→CF, 100→E6
- Simultaneous events:
  - A new req arriving in the done cycle is sampled in the following IDLE cycle.
  - A held req from the loser wins the next arbitration.

Optional Feature:
- Macro ALU_SHARE_STATS_EN.
- Defined: count0/count1 increment (wrapping 255→0) on the edge that asserts done[0]/done[1], and clear on reset.
- Undefined: count0/count1 are tied to 8'h00 and no counter registers are built.

Test Plan:
- Reset, then req=01, a0=3'b001, b0=3'b010, op0=00 → gnt=01 one cycle after sampling; done=01 the next cycle; result=011, ovf=0, seg=4F.
- req=10, a1=3'b011, b1=3'b001, op1=00 → result=100 (-4), ovf=1, seg=E6.
- req=11 held continuously, both requesters sub: 3-1 (req0) and 0-1 (req1) → grants alternate 01,10,01 each 3 cycles apart; results 010 then 111 (seg 86); ovf=0.
- EXEC_CYCLES=4, req=01, op0=10, a0=110, b0=011 → done exactly 4 cycles after gnt; result=010; busy high from the gnt cycle through the done cycle.
- Assert reset during EXEC → no done pulse; next cycle result=0, seg=3F, busy=0; a following req=11 is granted to requester 0.
- With ALU_SHARE_STATS_EN: 256 requester-0 ops → count0 wraps to 0, count1=0. Without the macro: both counters stay 0.
